// File: rtl/arbitro_rr_pkg.sv
// ---------------------------------------------------------------------------
// arbitro_rr_pkg
// Shared definitions for the 4-to-1 round-robin merge arbiter (arbitro_rr)
// and its priority search (rr_pick):
//   ARB_DATA_W  default word width
//   ARB_NPORTS  number of source ports
//   ARB_TAG_W   width of the destination tag held in the top bits of a word
//   arb_state_t IDLE / SERVE encoding of the arbiter state machine
// ---------------------------------------------------------------------------
package arbitro_rr_pkg;

   localparam int ARB_DATA_W = 10;
   localparam int ARB_NPORTS = 4;
   localparam int ARB_TAG_W  = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } arb_state_t;

   // Lowest bit of the destination tag field for a word of width dw;
   // the tag occupies [dw-1:dw-ARB_TAG_W].
   function automatic int tag_lsb(input int dw);
      return dw - ARB_TAG_W;
   endfunction

endpackage

// File: rtl/arbitro_rr_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin priority search.
// Ports:
//   req        in   4  request vector, bit i = port i wants service
//   last_grant in   2  index of the port served most recently
//   grant      out  4  one-hot winner, zero when nothing requests
// The search starts at last_grant+1 and wraps 3->0, so the port that was
// just served has the lowest priority on the next decision.
// ---------------------------------------------------------------------------
module rr_pick
   import arbitro_rr_pkg::*;
(
   input  logic [ARB_NPORTS-1:0] req,
   input  logic [1:0]            last_grant,
   output logic [ARB_NPORTS-1:0] grant
);

   logic       found;
   logic [1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= ARB_NPORTS; k++) begin
         // 2-bit add wraps naturally; k=4 lands back on last_grant itself.
         idx = last_grant + 2'(k);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbitro_rr.sv
// ---------------------------------------------------------------------------
// arbitro_rr
// Merges four first-word-fall-through source FIFOs into one stream using
// round-robin arbitration (reverse path of the 4-way destination router).
// Words are forwarded unmodified, destination tag included.
// Ports:
//   clk          in   1       clock, all state on rising edge
//   reset_L      in   1       asynchronous active-low reset
//   fifo_empty   in   4       bit i high = source FIFO i is empty
//   in0..in3     in   DATA_W  head word of source FIFO i
//   pop          out  4       one-hot combinational read strobe
//   almost_full  in   1       downstream cannot take another word
//   data_out     out  DATA_W  forwarded word (registered, latency 1)
//   push_out     out  1       data_out valid / downstream write strobe
//   idle         out  1       no grant outstanding and all sources empty
//   cnt0..cnt3   out  8       per-port pop counters, saturating at 255
//                             (present only with ARB_COUNT_EN defined)
// Optional feature macro: ARB_COUNT_EN
// ---------------------------------------------------------------------------
module arbitro_rr
   import arbitro_rr_pkg::*;
#(
   parameter int          DATA_W  = ARB_DATA_W,
   parameter int unsigned PTR_RST = 0
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic [ARB_NPORTS-1:0] fifo_empty,
   input  logic [DATA_W-1:0]     in0,
   input  logic [DATA_W-1:0]     in1,
   input  logic [DATA_W-1:0]     in2,
   input  logic [DATA_W-1:0]     in3,
   output logic [ARB_NPORTS-1:0] pop,
   input  logic                  almost_full,
   output logic [DATA_W-1:0]     data_out,
   output logic                  push_out,
   output logic                  idle
`ifdef ARB_COUNT_EN
   ,
   output logic [7:0]            cnt0,
   output logic [7:0]            cnt1,
   output logic [7:0]            cnt2,
   output logic [7:0]            cnt3
`endif
);

   // last_grant starts one below PTR_RST so the first search begins at PTR_RST.
   localparam logic [1:0] LG_RST = 2'((PTR_RST + 3) % 4);

   arb_state_t              state, state_nxt;
   logic [1:0]              last_grant;
   logic [ARB_NPORTS-1:0]   grant;
   logic                    pop_any;
   logic [1:0]              pop_idx;
   logic [DATA_W-1:0]       sel_word_p0;
   logic [DATA_W-1:0]       data_p1;
   logic                    vld_p1;

   rr_pick u_pick (
      .req        (~fifo_empty),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // ---- stage p0: grant, pop strobe and word select (combinational) ----
   // Pop is also gated by reset_L so no FIFO is read while reset is held.
   assign pop     = (reset_L && !almost_full) ? grant : '0;
   assign pop_any = |pop;

   always_comb begin
      sel_word_p0 = '0;
      pop_idx     = '0;
      unique case (pop)
         4'b0001: begin sel_word_p0 = in0; pop_idx = 2'd0; end
         4'b0010: begin sel_word_p0 = in1; pop_idx = 2'd1; end
         4'b0100: begin sel_word_p0 = in2; pop_idx = 2'd2; end
         4'b1000: begin sel_word_p0 = in3; pop_idx = 2'd3; end
         default: begin sel_word_p0 = '0;  pop_idx = '0;   end
      endcase
   end

   // ---- stage p1: registered output word and its valid ----
   // data_p1 is cleared by reset so an in-flight word is discarded.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         vld_p1     <= 1'b0;
         data_p1    <= '0;
         last_grant <= LG_RST;
      end else begin
         vld_p1 <= pop_any;
         if (pop_any) begin
            data_p1    <= sel_word_p0;
            last_grant <= pop_idx;
         end
      end
   end

   assign data_out = data_p1;
   assign push_out = vld_p1;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pop_any)  state_nxt = SERVE;
         SERVE:   if (!pop_any) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign idle = !reset_L ||
                 ((state == IDLE) && (&fifo_empty) && !vld_p1);

`ifdef ARB_COUNT_EN
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [7:0] cnt_q [ARB_NPORTS];

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < ARB_NPORTS; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < ARB_NPORTS; i++)
            if (pop[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
      end
   end

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];
   assign cnt2 = cnt_q[2];
   assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
module tb_arbitro_rr;

   localparam int DW = 10;

   logic          clk = 1'b0;
   logic          reset_L;
   logic [3:0]    fifo_empty;
   logic [DW-1:0] in0, in1, in2, in3;
   logic [3:0]    pop;
   logic          almost_full;
   logic [DW-1:0] data_out;
   logic          push_out;
   logic          idle;
`ifdef ARB_COUNT_EN
   logic [7:0]    cnt0, cnt1, cnt2, cnt3;
`endif

   int total = 0;
   int bad   = 0;

   // model state
   int            m_lg;
   logic [DW-1:0] m_last;
   logic          exp_push;
   logic [DW-1:0] q[$];

   always #5 clk = ~clk;

   arbitro_rr #(.DATA_W(DW), .PTR_RST(0)) dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .fifo_empty  (fifo_empty),
      .in0         (in0),
      .in1         (in1),
      .in2         (in2),
      .in3         (in3),
      .pop         (pop),
      .almost_full (almost_full),
      .data_out    (data_out),
      .push_out    (push_out),
      .idle        (idle)
`ifdef ARB_COUNT_EN
      ,
      .cnt0        (cnt0),
      .cnt1        (cnt1),
      .cnt2        (cnt2),
      .cnt3        (cnt3)
`endif
   );

   function automatic logic [3:0] model_pick();
      int p;
      if (!reset_L || almost_full) return 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         p = (m_lg + k) % 4;
         if (fifo_empty[p] == 1'b0) return 4'(1 << p);
      end
      return 4'b0000;
   endfunction

   function automatic logic [DW-1:0] word_at(input int p);
      case (p)
         0: return in0;
         1: return in1;
         2: return in2;
         default: return in3;
      endcase
   endfunction

   // One clock of checking: pop at mid-cycle, then push_out/data_out after the edge.
   task automatic cycle_chk(input string nm, output logic [3:0] seen);
      logic [3:0]    ep;
      logic [DW-1:0] ed;
      int            p;
      #1;
      ep   = model_pick();
      seen = pop;
      total++;
      if (pop !== ep) begin
         bad++;
         $display("FAIL %s pop got=%b exp=%b", nm, pop, ep);
      end
      if (ep != 4'b0000) begin
         p = 0;
         for (int i = 0; i < 4; i++) if (ep[i]) p = i;
         q.push_back(word_at(p));
         m_lg     = p;
         exp_push = 1'b1;
      end else begin
         exp_push = 1'b0;
      end
      @(posedge clk); #1;
      total++;
      if (push_out !== exp_push) begin
         bad++;
         $display("FAIL %s push_out got=%b exp=%b", nm, push_out, exp_push);
      end
      if (exp_push && q.size() > 0) begin
         ed     = q.pop_front();
         m_last = ed;
      end else begin
         ed = m_last;
      end
      total++;
      if (data_out !== ed) begin
         bad++;
         $display("FAIL %s data_out got=%h exp=%h", nm, data_out, ed);
      end
   endtask

   task automatic do_reset();
      reset_L = 1'b0;
      q.delete();
      m_lg     = 3;
      m_last   = '0;
      exp_push = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      fifo_empty  = 4'b0000;
      almost_full = 1'b0;
      in0 = 10'h3A5; in1 = 10'h011; in2 = 10'h222; in3 = 10'h333;
      reset_L = 1'b0;
      @(posedge clk); #2;
      total++;
      if (pop !== 4'b0000) begin bad++; $display("FAIL reset_pop got=%b exp=0000", pop); end
      total++;
      if (push_out !== 1'b0) begin bad++; $display("FAIL reset_push got=%b exp=0", push_out); end
      total++;
      if (data_out !== '0) begin bad++; $display("FAIL reset_data got=%h exp=000", data_out); end
      total++;
      if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
      fifo_empty = 4'b1111;
      do_reset();
   endtask

   task automatic test_lone();
      logic [3:0] s;
      do_reset();
      fifo_empty = 4'b1110;
      in0 = 10'h155;
      for (int i = 0; i < 6; i++) begin
         cycle_chk("lone", s);
         total++;
         if (s !== 4'b0001) begin bad++; $display("FAIL lone_pop%0d got=%b exp=0001", i, s); end
      end
   endtask

   task automatic test_all_four();
      logic [3:0] s;
      logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      fifo_empty = 4'b1111;
      do_reset();
      in0 = 10'h0C1; in1 = 10'h2F0; in2 = 10'h3FF; in3 = 10'h000;
      fifo_empty = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         cycle_chk("all4", s);
         total++;
         if (s !== seq[i]) begin bad++; $display("FAIL all4_seq%0d got=%b exp=%b", i, s, seq[i]); end
      end
      in0 = 10'h1AB; in3 = 10'h301;
      for (int i = 0; i < 4; i++) cycle_chk("all4b", s);
      fifo_empty = 4'b1111;
      cycle_chk("all4_drain", s);
   endtask

   task automatic test_almost_full();
      logic [3:0] s;
      do_reset();
      in1 = 10'h0A1; in3 = 10'h3C3;
      fifo_empty  = 4'b0101;
      almost_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle_chk("af_hold", s);
         total++;
         if (s !== 4'b0000) begin bad++; $display("FAIL af_hold%0d got=%b exp=0000", i, s); end
      end
      almost_full = 1'b0;
      cycle_chk("af_first", s);
      total++;
      if (s !== 4'b0010) begin bad++; $display("FAIL af_first got=%b exp=0010", s); end
      cycle_chk("af_second", s);
      total++;
      if (s !== 4'b1000) begin bad++; $display("FAIL af_second got=%b exp=1000", s); end
      fifo_empty = 4'b1111;
      cycle_chk("af_drain", s);
   endtask

   task automatic test_reset_mid();
      logic [3:0] s;
      do_reset();
      in2 = 10'h2B7;
      fifo_empty = 4'b1011;
      cycle_chk("mid_pop2", s);
      reset_L = 1'b0;
      #1;
      total++;
      if (push_out !== 1'b0) begin bad++; $display("FAIL mid_push got=%b exp=0", push_out); end
      total++;
      if (data_out !== '0) begin bad++; $display("FAIL mid_data got=%h exp=000", data_out); end
      q.delete();
      m_lg = 3; m_last = '0; exp_push = 1'b0;
      fifo_empty = 4'b0000;
      in0 = 10'h111; in1 = 10'h122; in3 = 10'h133;
      @(posedge clk); #1;
      reset_L = 1'b1;
      cycle_chk("mid_after", s);
      total++;
      if (s !== 4'b0001) begin bad++; $display("FAIL mid_first got=%b exp=0001", s); end
      fifo_empty = 4'b1111;
      cycle_chk("mid_drain", s);
   endtask

   task automatic test_idle();
      logic [3:0] s;
      do_reset();
      in0 = 10'h2C9;
      fifo_empty = 4'b1110;
      cycle_chk("idle_pre", s);
      fifo_empty = 4'b1111;
      cycle_chk("idle_enter", s);
      for (int i = 0; i < 5; i++) begin
         cycle_chk("idle_run", s);
         total++;
         if (idle !== 1'b1) begin bad++; $display("FAIL idle%0d got=%b exp=1", i, idle); end
      end
      fifo_empty = 4'b0111;
      in3 = 10'h0F0;
      #1;
      total++;
      if (idle !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", idle); end
      cycle_chk("idle_exit", s);
      fifo_empty = 4'b1111;
      cycle_chk("idle_drain", s);
   endtask

`ifdef ARB_COUNT_EN
   task automatic test_counters();
      logic [3:0] s;
      do_reset();
      in2 = 10'h0E2;
      fifo_empty = 4'b1011;
      for (int i = 0; i < 300; i++) cycle_chk("cnt_run", s);
      fifo_empty = 4'b1111;
      total++;
      if (cnt2 !== 8'd255) begin bad++; $display("FAIL cnt2 got=%0d exp=255", cnt2); end
      total++;
      if ({cnt0, cnt1, cnt3} !== 24'd0) begin
         bad++;
         $display("FAIL cnt_other got=%0d,%0d,%0d exp=0,0,0", cnt0, cnt1, cnt3);
      end
   endtask
`endif

   initial begin
      reset_L = 1'b0;
      fifo_empty = 4'b1111;
      almost_full = 1'b0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      m_lg = 3; m_last = '0; exp_push = 1'b0;
      test_reset();
      test_lone();
      test_all_four();
      test_almost_full();
      test_reset_mid();
      test_idle();
`ifdef ARB_COUNT_EN
      test_counters();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arbitro_rr.md
ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 Parameter DATA_W, default 10, word width; bits [DATA_W-1:DATA_W-2] carry the 2-bit destination tag.
REQ-002 Parameter PTR_RST, default 0, port that receives first priority after reset.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 fifo_empty  input  4  bit i high = source FIFO i holds no word.
REQ-006 in0, in1, in2, in3  input  DATA_W each  head word of source FIFO i (first-word-fall-through, valid while fifo_empty[i] low).
REQ-007 pop  output  4  one-hot read strobe to source FIFO i.
REQ-008 almost_full  input  1  downstream FIFO cannot accept beyond the word already in flight.
REQ-009 data_out  output  DATA_W  forwarded word.
REQ-010 push_out  output  1  data_out valid this cycle; write strobe to downstream FIFO.
REQ-011 idle  output  1  high when the block holds no grant and all sources are empty.

Function
REQ-012 The block SHALL merge the four source FIFOs into one stream using round-robin arbitration, the reverse path of the 4-way destination router.
REQ-013 Request i SHALL be fifo_empty[i]==0; pop SHALL be combinational, at most one bit high, and all zero while almost_full is high.
REQ-014 The winner SHALL be the first requesting port searched from (last_grant+1) mod 4 upward, wrapping 3->0.
REQ-015 last_grant SHALL update only on a cycle in which a pop is issued.
REQ-016 On a pop of port p at cycle N, data_out SHALL equal in_p and push_out SHALL be high at cycle N+1 (latency 1, registered).
REQ-017 With no pop at cycle N, push_out SHALL be 0 at N+1 and data_out SHALL hold its previous value.
REQ-018 Words SHALL be forwarded unmodified, including the destination tag and all-zero words.
REQ-019 A lone requester SHALL be popped every cycle (full throughput); four continuous requesters SHALL be served in order p+1, p+2, p+3, p.
REQ-020 Requests that appear while almost_full is high SHALL be served on the first cycle it is low, in round-robin order.
REQ-021 State machine: IDLE (no request or almost_full high) -> SERVE (pop issued); SERVE -> SERVE while a pop is issued; SERVE -> IDLE otherwise.
REQ-022 idle SHALL be high in IDLE with fifo_empty==4'b1111 and push_out low.

Reset
REQ-023 While reset_L is low: pop=0, push_out=0, data_out=0, idle=1, state=IDLE, last_grant=(PTR_RST-1) mod 4.
REQ-024 Reset asserted mid-transfer SHALL discard the in-flight word; first pop after release SHALL occur no earlier than the first rising edge with reset_L high.

Configuration
REQ-025 With ARB_COUNT_EN defined, the block SHALL add outputs cnt0..cnt3 (8 bits each), counting pops per port, saturating at 255, cleared by reset.
REQ-026 Without ARB_COUNT_EN, those ports and counters SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-027 Shared package SHALL hold DATA_W default, port count 4, tag field position, and the IDLE/SERVE state encoding.
REQ-028 Round-robin priority search SHALL be a sub-module rr_pick (4 requests, last_grant in; one-hot grant out, purely combinational).

Verification
REQ-029 Reset, fifo_empty=4'b1110, in0=10'h155, almost_full=0 -> pop=4'b0001 each cycle; push_out=1, data_out=10'h155 from the next cycle.
REQ-030 All four ports requesting continuously after reset -> pop sequence 0001,0010,0100,1000,0001; data_out follows one cycle later.
REQ-031 Ports 1 and 3 requesting, almost_full high 3 cycles then low -> no pop during the 3 cycles; then port 1, then port 3.
REQ-032 reset_L pulled low the cycle after a pop of port 2 -> push_out=0, data_out=0 immediately; after release, port 0 granted first.
REQ-033 All empty for 5 cycles -> pop=0, push_out=0, idle=1, data_out unchanged.
REQ-034 ARB_COUNT_EN defined, port 2 popped 300 times -> cnt2=255, other counters 0.
